inverse_subbytes_seq: RTL

Sequential, parametrised AES byte-substitution engine for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and substitutes LANES bytes per cycle through LANES instances of `Inverse_sbox`. It returns the substituted state over a second valid/ready handshake. It sits between the inverse ShiftRows and AddRoundKey stages and trades area for latency through the LANES parameter.

---
 rtl/inverse_subbytes_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/inverse_subbytes_seq.sv
// inverse_subbytes_seq: sequential AES SubBytes engine, LANES bytes per cycle, MSB byte first.
// Define SUBBYTES_FWD_MODE_EN to add forward S-boxes selected per state by mode.
module inverse_subbytes_seq #(
   parameter int unsigned LANES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] sb_in,
   input  logic         mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] sb_out,
   output logic         busy
);

   localparam int unsigned N  = 16 / LANES;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inverse_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
   end

   logic [1:0]    fsm, fsm_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [127:0]  data_q, data_nxt;
   logic          out_valid_nxt, busy_nxt;
   logic          accept;
   logic [7:0]    lane_x [LANES];
   logic [7:0]    lane_y [LANES];

   // in_ready is forced low during reset; it only looks at out_ready while holding a result
   assign in_ready = rst_n && ((fsm == S_IDLE) || ((fsm == S_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign sb_out   = data_q;

   // Lane input mux: the LANES bytes of the current group
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) lane_x[l] = 8'h00;
      for (int b = 0; b < 16; b++) begin
         if (CW'(b / int'(LANES)) == cnt) lane_x[b % int'(LANES)] = data_q[127 - 8*b -: 8];
      end
   end

`ifdef SUBBYTES_FWD_MODE_EN
   logic mode_q, mode_nxt;
`else
   logic unused_mode;
   assign unused_mode = mode;
`endif

   for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
`ifdef SUBBYTES_FWD_MODE_EN
      logic [7:0] inv_y, fwd_y;
      Inverse_sbox u_inv (.x(lane_x[l]), .y(inv_y));
      Sbox         u_fwd (.x(lane_x[l]), .y(fwd_y));
      assign lane_y[l] = mode_q ? fwd_y : inv_y;
`else
      Inverse_sbox u_inv (.x(lane_x[l]), .y(lane_y[l]));
`endif
   end

   // Next-state and datapath update
   always_comb begin
      fsm_nxt  = fsm;
      cnt_nxt  = cnt;
      data_nxt = data_q;
`ifdef SUBBYTES_FWD_MODE_EN
      mode_nxt = mode_q;
`endif
      unique case (fsm)
         S_IDLE: ;
         S_RUN: begin
            for (int b = 0; b < 16; b++) begin
               if (CW'(b / int'(LANES)) == cnt) data_nxt[127 - 8*b -: 8] = lane_y[b % int'(LANES)];
            end
            if (cnt == CW'(N - 1)) fsm_nxt = S_DONE;
            else                   cnt_nxt = cnt + CW'(1);
         end
         S_DONE: if (out_ready) fsm_nxt = S_IDLE;
         default: fsm_nxt = S_IDLE;
      endcase
      // Accept is only possible in IDLE or DONE; it overrides the release-to-IDLE
      if (accept) begin
         fsm_nxt  = S_RUN;
         cnt_nxt  = '0;
         data_nxt = sb_in;
`ifdef SUBBYTES_FWD_MODE_EN
         mode_nxt = mode;
`endif
      end
      out_valid_nxt = (fsm_nxt == S_DONE);
      busy_nxt      = (fsm_nxt == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= S_IDLE;
         cnt       <= '0;
         data_q    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef SUBBYTES_FWD_MODE_EN
         mode_q    <= 1'b0;
`endif
      end else begin
         fsm       <= fsm_nxt;
         cnt       <= cnt_nxt;
         data_q    <= data_nxt;
         out_valid <= out_valid_nxt;
         busy      <= busy_nxt;
`ifdef SUBBYTES_FWD_MODE_EN
         mode_q    <= mode_nxt;
`endif
      end
   end

endmodule

// GF(2^8) multiplicative inverse (x^254, 0 maps to 0) over the AES polynomial 0x11B.
module gf_inv (
   input  logic [7:0] x,
   output logic [7:0] y
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x12, x15, x240, x252;

   // Addition chain 2,3,12,15,240,252,254
   always_comb begin
      x2   = gmul(x, x);
      x3   = gmul(x2, x);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x15  = gmul(x12, x3);
      x240 = gmul(gmul(x15, x15), gmul(x15, x15));
      x240 = gmul(gmul(x240, x240), gmul(x240, x240));
      x252 = gmul(x240, x12);
      y    = gmul(x252, x2);
   end

endmodule

// AES inverse S-box: inverse affine transform followed by field inversion.
module Inverse_sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);
   logic [7:0] pre;
   assign pre = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
   gf_inv u_gf (.x(pre), .y(y));
endmodule

`ifdef SUBBYTES_FWD_MODE_EN
// AES forward S-box: field inversion followed by the affine transform.
module Sbox (
   input  logic [7:0] x,
   output logic [7:0] y
);
   logic [7:0] i;
   gf_inv u_gf (.x(x), .y(i));
   assign y = i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
endmodule
`endif
